// File: rtl/perceptron_pkg.sv
// Shared types, default widths and the saturation helper for the perceptron classifier stage.
package perceptron_pkg;

  localparam int DEF_NUM_CLASSES = 2;
  localparam int DEF_SCORE_WIDTH = 16;
  localparam int DEF_BIAS_WIDTH  = 8;

  typedef enum logic {COLLECT, RESULT} state_t;

  typedef enum logic [1:0] {SAT_NONE, SAT_POS, SAT_NEG} sat_t;

  // Two's-complement add overflows only when both operands share a sign the sum lacks.
  function automatic sat_t sat_add(input logic sign_a, input logic sign_b, input logic sign_sum);
    if ((sign_a == sign_b) && (sign_sum != sign_a))
      return sign_a ? SAT_NEG : SAT_POS;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/perceptron_sat_add.sv
// Combinational signed adder clamping to the representable range instead of wrapping.
module perceptron_sat_add
  import perceptron_pkg::*;
#(
  parameter int WIDTH = DEF_SCORE_WIDTH
)(
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);

  logic signed [WIDTH-1:0] sum;

  assign sum = a + b;

  always_comb begin
    y = sum;
    case (sat_add(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]))
      SAT_POS: y = {1'b0, {(WIDTH-1){1'b1}}};
      SAT_NEG: y = {1'b1, {(WIDTH-1){1'b0}}};
      default: y = sum;
    endcase
  end

endmodule

// File: rtl/perceptron_argmax.sv
// Biased argmax over one frame of class scores; emits one registered winner per frame.
//   state   | meaning
//   COLLECT | accepting scores, tracking running max and its index
//   RESULT  | result_* held valid until consumer handshake, scores back-pressured
module perceptron_argmax
  import perceptron_pkg::*;
#(
  parameter  int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter  int SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter  int BIAS_WIDTH  = DEF_BIAS_WIDTH,
  localparam int IDX_WIDTH   = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SCORE_WIDTH-1:0] score_in,
  input  logic                   score_valid,
  input  logic                   score_last,
  output logic                   score_ready,
  input  logic                   bias_wen,
  input  logic [IDX_WIDTH-1:0]   bias_addr,
  input  logic [BIAS_WIDTH-1:0]  bias_data,
  output logic [IDX_WIDTH-1:0]   result_idx,
  output logic [SCORE_WIDTH-1:0] result_score,
  output logic                   result_err,
  output logic                   result_valid,
  input  logic                   result_ready
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [IDX_WIDTH:0]   NUM_CLS  = (IDX_WIDTH + 1)'(NUM_CLASSES);

  state_t                        state;
  logic [IDX_WIDTH-1:0]          cnt;
  logic [IDX_WIDTH-1:0]          run_idx;
  logic [IDX_WIDTH-1:0]          nxt_idx;
  logic signed [SCORE_WIDTH-1:0] run_max;
  logic signed [SCORE_WIDTH-1:0] nxt_max;
  logic signed [SCORE_WIDTH-1:0] biased;
  logic signed [SCORE_WIDTH-1:0] bias_ext;
  logic [BIAS_WIDTH-1:0]         bias_tbl [NUM_CLASSES];
  logic                          accept;
  logic                          at_last;

  assign score_ready = (state == COLLECT);
  assign accept      = score_valid && score_ready;
  assign at_last     = (cnt == LAST_IDX);
  assign bias_ext    = {{(SCORE_WIDTH-BIAS_WIDTH){bias_tbl[cnt][BIAS_WIDTH-1]}}, bias_tbl[cnt]};

  perceptron_sat_add #(.WIDTH(SCORE_WIDTH)) u_sat_add (
    .a (score_in),
    .b (bias_ext),
    .y (biased)
  );

  // Strict compare so ties keep the earlier (lower) class index.
  always_comb begin
    nxt_max = run_max;
    nxt_idx = run_idx;
    if ((cnt == '0) || (biased > run_max)) begin
      nxt_max = biased;
      nxt_idx = cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= COLLECT;
      cnt          <= '0;
      run_idx      <= '0;
      run_max      <= '0;
      result_idx   <= '0;
      result_score <= '0;
      result_err   <= 1'b0;
      result_valid <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++)
        bias_tbl[i] <= '0;
    end else begin
      // The accept above reads the table before this write lands, so it sees the old bias.
      if (bias_wen && ({1'b0, bias_addr} < NUM_CLS))
        bias_tbl[bias_addr] <= bias_data;

      case (state)
        COLLECT: begin
          if (accept) begin
            run_max <= nxt_max;
            run_idx <= nxt_idx;
            if (at_last || score_last) begin
              result_idx   <= nxt_idx;
              result_score <= nxt_max;
              result_err   <= (score_last != at_last);
              result_valid <= 1'b1;
              cnt          <= '0;
              state        <= RESULT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RESULT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_argmax.sv
// Directed bench for perceptron_argmax: a 2-class and a 4-class instance on a shared clock/reset.
module tb_perceptron_argmax;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [15:0] s_in = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic        b_wen = 1'b0;
  logic [1:0]  b_addr = '0;
  logic [7:0]  b_data = '0;
  logic [1:0]  r_idx;
  logic [15:0] r_score;
  logic        r_err, r_valid;
  logic        r_ready = 1'b1;

  logic [15:0] t_in = '0;
  logic        t_valid = 1'b0, t_last = 1'b0, t_ready;
  logic        t_wen = 1'b0;
  logic [0:0]  t_addr = '0;
  logic [7:0]  t_data = '0;
  logic [0:0]  t_idx;
  logic [15:0] t_score;
  logic        t_err, t_valid_o;
  logic        t_rready = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perceptron_argmax #(.NUM_CLASSES(4), .SCORE_WIDTH(16), .BIAS_WIDTH(8)) dut4 (
    .clk(clk), .rst(rst),
    .score_in(s_in), .score_valid(s_valid), .score_last(s_last), .score_ready(s_ready),
    .bias_wen(b_wen), .bias_addr(b_addr), .bias_data(b_data),
    .result_idx(r_idx), .result_score(r_score), .result_err(r_err),
    .result_valid(r_valid), .result_ready(r_ready)
  );

  perceptron_argmax #(.NUM_CLASSES(2), .SCORE_WIDTH(16), .BIAS_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst),
    .score_in(t_in), .score_valid(t_valid), .score_last(t_last), .score_ready(t_ready),
    .bias_wen(t_wen), .bias_addr(t_addr), .bias_data(t_data),
    .result_idx(t_idx), .result_score(t_score), .result_err(t_err),
    .result_valid(t_valid_o), .result_ready(t_rready)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int sc, input bit last);
    int n = 0;
    s_in = 16'(sc);
    s_last = last;
    s_valid = 1'b1;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send2(input int sc, input bit last);
    int n = 0;
    t_in = 16'(sc);
    t_last = last;
    t_valid = 1'b1;
    while (!t_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!t_ready) chk("send2_timeout", 0, 1);
    @(posedge clk); #1;
    t_valid = 1'b0;
    t_last = 1'b0;
  endtask

  task automatic set_bias(input int addr, input int val);
    b_wen = 1'b1;
    b_addr = 2'(addr);
    b_data = 8'(val);
    @(posedge clk); #1;
    b_wen = 1'b0;
  endtask

  task automatic send_frame(input int sc[4], input int n, input bit last_at_end);
    for (int i = 0; i < n; i++)
      send(sc[i], last_at_end && (i == n - 1));
  endtask

  // Called #1 after the closing accept edge: result must already be up (1-cycle latency).
  task automatic expect_result(input string tag, input int idx, input int score, input int err);
    chk({tag, "_valid"}, int'(r_valid), 1);
    chk({tag, "_idx"}, int'(r_idx), idx);
    chk({tag, "_score"}, int'($signed(r_score)), score);
    chk({tag, "_err"}, int'(r_err), err);
    if (r_ready) begin
      @(posedge clk); #1;
      chk({tag, "_cleared"}, int'(r_valid), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    #12;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid", int'(r_valid), 0);
    chk("rst_idx", int'(r_idx), 0);
    chk("rst_score", int'(r_score), 0);
    chk("rst_err", int'(r_err), 0);

    send2(5, 1'b0);
    chk("n2_early_valid", int'(t_valid_o), 0);
    send2(-3, 1'b1);
    chk("n2_valid", int'(t_valid_o), 1);
    chk("n2_idx", int'(t_idx), 0);
    chk("n2_score", int'($signed(t_score)), 5);
    chk("n2_err", int'(t_err), 0);

    set_bias(2, 10);
    send_frame('{20, 15, 12, -1}, 4, 1'b1);
    expect_result("bias", 2, 22, 0);

    set_bias(2, 0);
    send_frame('{7, 7, 3, 1}, 4, 1'b1);
    expect_result("tie", 0, 7, 0);

    set_bias(0, 100);
    send_frame('{32760, 0, 0, 0}, 4, 1'b1);
    expect_result("sat_pos", 0, 32767, 0);

    set_bias(0, 0);
    set_bias(1, -1);
    send_frame('{-32768, -32768, -32768, -32768}, 4, 1'b1);
    expect_result("sat_neg", 0, -32768, 0);

    set_bias(1, 0);
    send_frame('{1, 9, 0, 0}, 2, 1'b1);
    expect_result("early_last", 1, 9, 1);

    send_frame('{3, -2, 8, 8}, 4, 1'b0);
    expect_result("no_last", 2, 8, 1);

    r_ready = 1'b0;
    send_frame('{4, 6, 2, 1}, 4, 1'b1);
    s_in = 16'(11);
    s_last = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", i), int'(r_valid), 1);
      chk($sformatf("hold%0d_idx", i), int'(r_idx), 1);
      chk($sformatf("hold%0d_score", i), int'($signed(r_score)), 6);
      chk($sformatf("hold%0d_ready", i), int'(s_ready), 0);
    end
    r_ready = 1'b1;
    @(posedge clk); #1;
    chk("handshake_valid", int'(r_valid), 0);
    chk("handshake_ready", int'(s_ready), 1);
    send(11, 1'b0);
    send(2, 1'b0);
    send(3, 1'b0);
    send(-5, 1'b1);
    expect_result("queued", 0, 11, 0);

    set_bias(1, 50);
    send(100, 1'b0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    chk("mid_rst_valid", int'(r_valid), 0);
    chk("mid_rst_idx", int'(r_idx), 0);
    chk("mid_rst_score", int'(r_score), 0);
    chk("mid_rst_ready", int'(s_ready), 1);
    @(posedge clk); #1;
    send_frame('{1, 2, 3, 4}, 4, 1'b1);
    expect_result("post_rst", 3, 4, 0);

    s_in = 16'(-10);
    s_last = 1'b0;
    s_valid = 1'b1;
    b_wen = 1'b1;
    b_addr = 2'd0;
    b_data = 8'd20;
    @(posedge clk); #1;
    s_valid = 1'b0;
    b_wen = 1'b0;
    send(3, 1'b0);
    send(1, 1'b0);
    send(2, 1'b1);
    expect_result("old_bias", 1, 3, 0);

    send_frame('{-10, 3, 1, 2}, 4, 1'b1);
    expect_result("new_bias", 0, 10, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
